// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues data-memory requests, stalls until dhit, and holds the writeback register.
// Optional stall-cycle counter output memStallCount is built when MEM_WB_PERF_EN is defined.
module mem_wb_stage (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        memcuDRE,
   input  logic        memcuDWE,
   input  logic        memcuHALT,
   input  logic        memMemToReg,
   input  logic        memWEN,
   input  logic [4:0]  memwsel,
   input  logic [31:0] memOutput_Port,
   input  logic [31:0] memrdat2,
   input  logic [31:0] meminstr,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic        memSTALL,
   output logic        wbWEN,
   output logic [4:0]  wbwsel,
   output logic [31:0] wbwdat,
   output logic [31:0] wbinstr,
   output logic        wbHALT
`ifdef MEM_WB_PERF_EN
   ,
   output logic [31:0] memStallCount
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        w_access;
   logic        r_wb_wen;
   logic [4:0]  r_wb_wsel;
   logic [31:0] r_wb_wdat;
   logic [31:0] r_wb_instr;
   logic        r_wb_halt;

   // Requests are masked by reset so a reset arriving mid-WAIT drops them immediately.
   assign w_access = nRST && (r_state != HALTED) && (memcuDRE || memcuDWE) && !memcuHALT;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (memcuHALT)               w_next_state = HALTED;
            else if (w_access && !dhit)  w_next_state = WAIT;
         end
         WAIT: begin
            if (memcuHALT)               w_next_state = HALTED;
            else if (!memSTALL)          w_next_state = IDLE;
         end
         HALTED:                         w_next_state = HALTED;
         default:                        w_next_state = IDLE;
      endcase
   end

   always_comb begin
      dmemWEN   = w_access && memcuDWE;
      dmemREN   = w_access && memcuDRE && !memcuDWE;
      memSTALL  = w_access && !dhit;
      dmemaddr  = memOutput_Port;
      dmemstore = memrdat2;
   end

   // Writeback register: frozen once halted, bubbled while the memory access is pending.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_wb_wen   <= 1'b0;
         r_wb_wsel  <= '0;
         r_wb_wdat  <= '0;
         r_wb_instr <= '0;
         r_wb_halt  <= 1'b0;
      end else if (r_state == HALTED) begin
         r_wb_wen   <= 1'b0;
      end else if (memSTALL) begin
         r_wb_wen   <= 1'b0;
         r_wb_instr <= '0;
      end else begin
         r_wb_wen   <= memWEN && !memcuHALT;
         r_wb_wsel  <= memwsel;
         r_wb_wdat  <= memMemToReg ? dmemload : memOutput_Port;
         r_wb_instr <= meminstr;
         r_wb_halt  <= memcuHALT;
      end
   end

   assign wbWEN   = r_wb_wen;
   assign wbwsel  = r_wb_wsel;
   assign wbwdat  = r_wb_wdat;
   assign wbinstr = r_wb_instr;
   assign wbHALT  = r_wb_halt;

`ifdef MEM_WB_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_stall_cnt <= '0;
      end else if (memSTALL && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign memStallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus multi-cycle stall, halt and reset sequences.
module tb_mem_wb_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN;
   logic [4:0]  memwsel;
   logic [31:0] memOutput_Port, memrdat2, meminstr;
   logic        dhit;
   logic [31:0] dmemload;
   logic        dmemREN, dmemWEN, memSTALL;
   logic [31:0] dmemaddr, dmemstore;
   logic        wbWEN, wbHALT;
   logic [4:0]  wbwsel;
   logic [31:0] wbwdat, wbinstr;
`ifdef MEM_WB_PERF_EN
   logic [31:0] memStallCount;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   mem_wb_stage dut (
      .CLK(CLK), .nRST(nRST),
      .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
      .memMemToReg(memMemToReg), .memWEN(memWEN), .memwsel(memwsel),
      .memOutput_Port(memOutput_Port), .memrdat2(memrdat2), .meminstr(meminstr),
      .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .memSTALL(memSTALL), .wbWEN(wbWEN), .wbwsel(wbwsel), .wbwdat(wbwdat),
      .wbinstr(wbinstr), .wbHALT(wbHALT)
`ifdef MEM_WB_PERF_EN
      , .memStallCount(memStallCount)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        dre, dwe, halt, m2r, wen;
      logic [4:0]  wsel;
      logic [31:0] outp, rdat2, instr;
      logic        hit;
      logic [31:0] load;
      logic        e_ren, e_wen, e_stall, e_wbwen;
      logic [4:0]  e_wsel;
      logic [31:0] e_wdat, e_instr;
      logic        e_halt;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic dre, input logic dwe, input logic halt, input logic m2r,
                        input logic wen, input logic [4:0] wsel, input logic [31:0] outp,
                        input logic [31:0] rdat2, input logic [31:0] instr, input logic hit,
                        input logic [31:0] load);
      memcuDRE = dre; memcuDWE = dwe; memcuHALT = halt; memMemToReg = m2r; memWEN = wen;
      memwsel = wsel; memOutput_Port = outp; memrdat2 = rdat2; meminstr = instr;
      dhit = hit; dmemload = load;
   endtask

   task automatic edge_sample();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_wb(input string tag, input logic wen, input logic [4:0] wsel,
                         input logic [31:0] wdat, input logic [31:0] instr, input logic halt);
      chk({tag, ".wbWEN"},   {31'd0, wbWEN},  {31'd0, wen});
      chk({tag, ".wbwsel"},  {27'd0, wbwsel}, {27'd0, wsel});
      chk({tag, ".wbwdat"},  wbwdat,          wdat);
      chk({tag, ".wbinstr"}, wbinstr,         instr);
      chk({tag, ".wbHALT"},  {31'd0, wbHALT}, {31'd0, halt});
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      drive(0,0,0,0,0,5'd0,32'd0,32'd0,32'd0,1'b0,32'd0);
      edge_sample();
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      // dre dwe halt m2r wen wsel outp rdat2 instr hit load | ren wen stall | wbWEN wsel wdat instr halt
      vt[0] = '{0,0,0,0,1,5'd5,32'h1234,32'h0,32'hAAAA0001,1'b0,32'h0,       0,0,0, 1,5'd5,32'h1234,32'hAAAA0001,0};
      vt[1] = '{1,1,0,0,0,5'd0,32'h200,32'hCAFE0000,32'h22,1'b1,32'hFFFF,    0,1,0, 0,5'd0,32'h200,32'h22,0};
      vt[2] = '{1,0,0,1,1,5'd7,32'h300,32'h0,32'h33,1'b1,32'h55667788,       1,0,0, 1,5'd7,32'h55667788,32'h33,0};
      vt[3] = '{1,0,0,1,1,5'd9,32'h310,32'h0,32'h44,1'b0,32'h0,              1,0,1, 0,5'd7,32'h55667788,32'h0,0};
      vt[4] = '{1,0,0,1,1,5'd9,32'h310,32'h0,32'h44,1'b1,32'h99,             1,0,0, 1,5'd9,32'h99,32'h44,0};
      vt[5] = '{0,1,0,0,0,5'd0,32'h400,32'h77,32'h55,1'b0,32'h0,             0,1,1, 0,5'd9,32'h99,32'h0,0};
      vt[6] = '{0,1,0,0,0,5'd0,32'h400,32'h77,32'h55,1'b1,32'h0,             0,1,0, 0,5'd0,32'h400,32'h55,0};

      nRST = 1'b0;
      drive(1,1,0,1,1,5'd3,32'h1,32'h2,32'h3,1'b0,32'h4);
      #1;
      chk("rst.dmemREN",  {31'd0, dmemREN},  32'd0);
      chk("rst.dmemWEN",  {31'd0, dmemWEN},  32'd0);
      chk("rst.memSTALL", {31'd0, memSTALL}, 32'd0);
      edge_sample();
      edge_sample();
      chk_wb("rst", 0, 5'd0, 32'd0, 32'd0, 0);
`ifdef MEM_WB_PERF_EN
      chk("rst.count", memStallCount, 32'd0);
`endif
      @(negedge CLK);
      nRST = 1'b1;

      for (int i = 0; i < 7; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         drive(vt[i].dre, vt[i].dwe, vt[i].halt, vt[i].m2r, vt[i].wen, vt[i].wsel,
               vt[i].outp, vt[i].rdat2, vt[i].instr, vt[i].hit, vt[i].load);
         #1;
         chk({t, ".dmemREN"},   {31'd0, dmemREN},  {31'd0, vt[i].e_ren});
         chk({t, ".dmemWEN"},   {31'd0, dmemWEN},  {31'd0, vt[i].e_wen});
         chk({t, ".memSTALL"},  {31'd0, memSTALL}, {31'd0, vt[i].e_stall});
         chk({t, ".dmemaddr"},  dmemaddr,          vt[i].outp);
         chk({t, ".dmemstore"}, dmemstore,         vt[i].rdat2);
         edge_sample();
         chk_wb(t, vt[i].e_wbwen, vt[i].e_wsel, vt[i].e_wdat, vt[i].e_instr, vt[i].e_halt);
         @(negedge CLK);
      end

      // Load at 0x100 that completes after three stall cycles.
      do_reset();
      drive(1,0,0,1,1,5'd12,32'h100,32'h0,32'h8C0C0100,1'b0,32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("ld3.stall%0d", c), {31'd0, memSTALL}, 32'd1);
         chk($sformatf("ld3.ren%0d", c),   {31'd0, dmemREN},  32'd1);
         edge_sample();
         chk($sformatf("ld3.bubble%0d", c), {31'd0, wbWEN}, 32'd0);
         @(negedge CLK);
      end
      dhit = 1'b1; dmemload = 32'hDEADBEEF;
      #1;
      chk("ld3.stall_end", {31'd0, memSTALL}, 32'd0);
      edge_sample();
      chk_wb("ld3", 1, 5'd12, 32'hDEADBEEF, 32'h8C0C0100, 0);
`ifdef MEM_WB_PERF_EN
      chk("ld3.count", memStallCount, 32'd3);
`endif

      // Reset asserted while a load is waiting.
      @(negedge CLK);
      drive(1,0,0,1,1,5'd4,32'h180,32'h0,32'h8C040180,1'b0,32'h0);
      edge_sample();
      chk("rstwait.stall_pre", {31'd0, memSTALL}, 32'd1);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("rstwait.ren",   {31'd0, dmemREN},  32'd0);
      chk("rstwait.stall", {31'd0, memSTALL}, 32'd0);
      edge_sample();
      chk_wb("rstwait", 0, 5'd0, 32'd0, 32'd0, 0);
      @(negedge CLK);
      nRST = 1'b1;
      dhit = 1'b1; dmemload = 32'h0BADF00D;
      edge_sample();
      chk_wb("rstwait.after", 1, 5'd4, 32'h0BADF00D, 32'h8C040180, 0);

      // Halt: sticky, blocks later requests, cleared only by reset.
      @(negedge CLK);
      drive(1,0,1,0,1,5'd2,32'h500,32'h0,32'hFFFFFFFF,1'b0,32'h0);
      #1;
      chk("halt.ren",   {31'd0, dmemREN},  32'd0);
      chk("halt.stall", {31'd0, memSTALL}, 32'd0);
      edge_sample();
      chk("halt.wbHALT", {31'd0, wbHALT}, 32'd1);
      chk("halt.wbWEN",  {31'd0, wbWEN},  32'd0);
      @(negedge CLK);
      drive(1,0,0,1,1,5'd6,32'h600,32'h0,32'h1111,1'b0,32'h0);
      #1;
      chk("halted.ren",   {31'd0, dmemREN},  32'd0);
      chk("halted.stall", {31'd0, memSTALL}, 32'd0);
      edge_sample();
      @(negedge CLK);
      drive(0,1,0,0,1,5'd6,32'h600,32'h9,32'h2222,1'b1,32'h0);
      #1;
      chk("halted.wen", {31'd0, dmemWEN}, 32'd0);
      edge_sample();
      chk_wb("halted", 0, 5'd2, 32'h500, 32'hFFFFFFFF, 1);
`ifdef MEM_WB_PERF_EN
      chk("halted.count", memStallCount, 32'd0);
`endif
      do_reset();
      #1;
      chk("unhalt.wbHALT", {31'd0, wbHALT}, 32'd0);
      drive(1,0,0,1,1,5'd6,32'h600,32'h0,32'h3333,1'b1,32'h4444);
      #1;
      chk("unhalt.ren", {31'd0, dmemREN}, 32'd1);
      edge_sample();
      chk_wb("unhalt", 1, 5'd6, 32'h4444, 32'h3333, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock.
REQ-002 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN  input  1 each  EX/MEM-register control outputs.
REQ-004 SHALL have port memwsel  input  5  destination register select.
REQ-005 SHALL have ports memOutput_Port, memrdat2, meminstr  input  32 each  ALU result, store data, instruction.
REQ-006 SHALL have port dhit  input  1  data-memory access complete.
REQ-007 SHALL have port dmemload  input  32  data-memory read data, valid with dhit.
REQ-008 SHALL have ports dmemREN, dmemWEN  output  1 each  data-memory read/write request.
REQ-009 SHALL have ports dmemaddr, dmemstore  output  32 each  request address and store data.
REQ-010 SHALL have port memSTALL  output  1  freeze upstream pipeline registers.
REQ-011 SHALL have ports wbWEN  output  1, wbwsel  output  5, wbwdat  output  32, wbinstr  output  32  MEM/WB register contents.
REQ-012 SHALL have port wbHALT  output  1  sticky halt to the system.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and HALTED.
REQ-014 SHALL define an access as (memcuDRE | memcuDWE) & ~memcuHALT, in IDLE or WAIT only.
REQ-015 SHALL drive dmemWEN = access & memcuDWE, dmemREN = access & memcuDRE & ~memcuDWE (write wins if both set).
REQ-016 SHALL drive dmemaddr = memOutput_Port and dmemstore = memrdat2 combinationally.
REQ-017 SHALL drive memSTALL = access & ~dhit; 0 in HALTED.
REQ-018 SHALL transition IDLE->WAIT on access & ~dhit; WAIT->IDLE on dhit; IDLE/WAIT->HALTED when memcuHALT is captured.
REQ-019 SHALL capture the WB register on each rising edge where memSTALL=0 and state != HALTED; otherwise hold.
REQ-020 SHALL capture wbwdat = memMemToReg ? dmemload : memOutput_Port; wbwsel = memwsel; wbinstr = meminstr; wbWEN = memWEN.
REQ-021 SHALL produce zero-cycle latency on dhit in the same cycle as the request (no WAIT entry).
REQ-022 SHALL insert a bubble (wbWEN=0, wbinstr=0) on edges where memSTALL=1 while in IDLE/WAIT.
REQ-023 SHALL, in HALTED, force dmemREN=dmemWEN=0, wbWEN=0, and hold wbHALT=1 until reset.
REQ-024 SHALL treat the cycle where memcuHALT is captured as writing wbHALT=1 and wbWEN=0.

Reset
REQ-025 SHALL on a CLK edge with nRST=0 set state=IDLE and wbWEN, wbwsel, wbwdat, wbinstr, wbHALT to 0.
REQ-026 SHALL gate dmemREN, dmemWEN and memSTALL to 0 combinationally while nRST=0, including reset mid-WAIT.
REQ-027 SHALL on reset from HALTED return to IDLE with wbHALT cleared.

Configuration
REQ-028 SHALL, with MEM_WB_PERF_EN defined, add output memStallCount (32 bits, reset 0), incrementing on each edge with memSTALL=1 and saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without MEM_WB_PERF_EN, omit the port and counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover: load, memcuDRE=1, addr 0x100, dhit after 3 cycles, dmemload=0xDEADBEEF -> memSTALL high 3 cycles, then wbwdat=0xDEADBEEF, wbWEN=1; memStallCount=3 if enabled.
REQ-031 SHALL cover: store with both DRE and DWE=1, dhit same cycle -> dmemWEN=1, dmemREN=0, no stall, dmemstore=memrdat2.
REQ-032 SHALL cover: ALU op, memMemToReg=0, memOutput_Port=0x1234 -> next edge wbwdat=0x1234, wbwsel=memwsel.
REQ-033 SHALL cover: memcuHALT=1 -> next edge wbHALT=1, wbWEN=0; later access requests -> dmemREN=dmemWEN=0.
REQ-034 SHALL cover: nRST=0 asserted during WAIT -> dmemREN=0 immediately, state IDLE and all WB outputs 0 after the edge.
